uart_rx: RTL and testbench

Serial receive stage of the UART: samples the asynchronous `rx_bit` line at 16x the baud rate, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) and pushes each good byte into the RX FIFO that the Wishbone side pops. It sits between the `rx_bit` pad and the RX FIFO's push port and replaces the unused RX path inside the UART. Framing errors and FIFO overruns are reported as one-cycle strobes.

---
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx
// UART receive stage. Oversamples the asynchronous rx_bit line at 16x the
// baud rate, recovers 8N1 frames (start, 8 data LSB first, stop) and pushes
// each good byte toward the RX FIFO.
//
// Ports:
//   clk           system clock, all logic on posedge
//   reset         synchronous active-high reset
//   rx_bit        asynchronous serial input, idles high
//   freq_divider  oversample divider: one tick per freq_divider+1 clk cycles
//   rx_fifo_full  RX FIFO full flag, looked at only in the stop-bit decision
//   rx_data       last received byte, valid with rx_push and held afterwards
//   rx_push       one-cycle push strobe to the RX FIFO
//   frame_error   one-cycle strobe: stop bit sampled low
//   overrun       one-cycle strobe: good byte dropped because FIFO full
//   rx_busy       high whenever the receiver is not idle
module uart_rx (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_bit,
  input  logic [7:0] freq_divider,
  input  logic       rx_fifo_full,
  output logic [7:0] rx_data,
  output logic       rx_push,
  output logic       frame_error,
  output logic       overrun,
  output logic       rx_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e     state_q, state_d;
  logic       sync1_q, sync2_q;
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [3:0] sub_cnt_q, sub_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] smp_q, smp_d;        // [1] sample at sub_cnt 7, [0] at 8
  logic [7:0] rx_data_q, rx_data_d;
  logic       push_q, push_d;
  logic       fe_q, fe_d;
  logic       ov_q, ov_d;
  logic       tick;
  logic       maj;
  logic       rx_sync;

  assign rx_sync = sync2_q;

  always_comb begin
    // >= rather than == so a divider lowered mid-frame applies immediately
    tick       = (tick_cnt_q >= freq_divider);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 8'd1;

    // Majority of the samples at 7 and 8 plus the live sample at 9
    maj = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_sync) | (smp_q[0] & rx_sync);

    state_d   = state_q;
    sub_cnt_d = sub_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    smp_d     = smp_q;
    rx_data_d = rx_data_q;
    push_d    = 1'b0;
    fe_d      = 1'b0;
    ov_d      = 1'b0;

    if (tick) begin
      sub_cnt_d = sub_cnt_q + 4'd1;
      if (sub_cnt_q == 4'd7) smp_d[1] = rx_sync;
      if (sub_cnt_q == 4'd8) smp_d[0] = rx_sync;

      unique case (state_q)
        S_IDLE: begin
          if (!rx_sync) begin
            sub_cnt_d = '0;
            state_d   = S_START;
          end
        end
        S_START: begin
          if (sub_cnt_q == 4'd9 && maj) begin
            state_d = S_IDLE;       // glitch, not a start bit
          end else if (sub_cnt_q == 4'd15) begin
            bit_idx_d = '0;
            state_d   = S_DATA;
          end
        end
        S_DATA: begin
          if (sub_cnt_q == 4'd9) shift_d[bit_idx_q] = maj;
          if (sub_cnt_q == 4'd15) begin
            if (bit_idx_q == 3'd7) state_d = S_STOP;
            else                   bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        S_STOP: begin
          // Deciding at mid stop bit leaves half a bit of baud-mismatch slack
          if (sub_cnt_q == 4'd9) begin
            if (maj) begin
              if (rx_fifo_full) begin
                ov_d = 1'b1;
              end else begin
                rx_data_d = shift_q;
                push_d    = 1'b1;
              end
              state_d = S_IDLE;
            end else begin
              fe_d    = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          // Held-low line: wait for idle so no phantom frames follow
          if (rx_sync) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      tick_cnt_q <= '0;
      state_q    <= S_IDLE;
      sub_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      smp_q      <= '1;
      rx_data_q  <= '0;
      push_q     <= 1'b0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      sync1_q    <= rx_bit;
      sync2_q    <= sync1_q;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      sub_cnt_q  <= sub_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      smp_q      <= smp_d;
      rx_data_q  <= rx_data_d;
      push_q     <= push_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_push     = push_q;
  assign frame_error = fe_q;
  assign overrun     = ov_q;
  assign rx_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx: frames are driven bit by bit onto rx_bit and
// the strobes are tallied by a monitor; expected values are hand-computed.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_bit = 1'b1;
  logic [7:0] freq_divider = 8'd0;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] rx_data;
  logic       rx_push;
  logic       frame_error;
  logic       overrun;
  logic       rx_busy;

  int n_checks = 0;
  int n_errors = 0;

  // Monitor tallies
  int       cyc = 0;
  int       n_push = 0, n_fe = 0, n_ov = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;
  int       last_push_cyc = 0, prev_push_cyc = 0;
  int       busy_run = 0, busy_last = 0;

  uart_rx dut (
    .clk          (clk),
    .reset        (reset),
    .rx_bit       (rx_bit),
    .freq_divider (freq_divider),
    .rx_fifo_full (rx_fifo_full),
    .rx_data      (rx_data),
    .rx_push      (rx_push),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_push) begin
      n_push        <= n_push + 1;
      prev_data     <= last_data;
      last_data     <= rx_data;
      prev_push_cyc <= last_push_cyc;
      last_push_cyc <= cyc;
    end
    if (frame_error) n_fe <= n_fe + 1;
    if (overrun)     n_ov <= n_ov + 1;
    if (rx_busy) begin
      busy_run <= busy_run + 1;
    end else begin
      if (busy_run != 0) busy_last <= busy_run;
      busy_run <= 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v, input int unsigned bit_cyc);
    rx_bit = 1'b0;
    wait_cyc(bit_cyc);
    for (int unsigned i = 0; i < 8; i++) begin
      rx_bit = b[i];
      wait_cyc(bit_cyc);
    end
    rx_bit = stop_v;
    wait_cyc(bit_cyc);
  endtask

  int p0, f0, o0;

  task automatic snap();
    #1;
    p0 = n_push;
    f0 = n_fe;
    o0 = n_ov;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(1);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_strobes", {rx_push, frame_error, overrun}, 3'b000);
    chk("rst_busy", rx_busy, 1'b0);

    // 1: plain 0xA5
    snap();
    send_byte(8'hA5, 1'b1, 16);
    wait_cyc(32);
    #1;
    chk("t1_push", n_push - p0, 1);
    chk("t1_data", last_data, 8'hA5);
    chk("t1_fe_ov", (n_fe - f0) + (n_ov - o0), 0);
    chk("t1_busy", rx_busy, 1'b0);

    // 2: 3-cycle glitch; busy stretch is 10 cycles by construction
    snap();
    rx_bit = 1'b0;
    wait_cyc(3);
    rx_bit = 1'b1;
    wait_cyc(40);
    #1;
    chk("t2_strobes", (n_push - p0) + (n_fe - f0) + (n_ov - o0), 0);
    chk("t2_busy_len", busy_last, 10);
    chk("t2_busy", rx_busy, 1'b0);

    // 3: framing error, long break, then 0x55
    snap();
    send_byte(8'h3C, 1'b0, 16);
    wait_cyc(40 * 16);
    rx_bit = 1'b1;
    wait_cyc(32);
    #1;
    chk("t3_fe", n_fe - f0, 1);
    chk("t3_nopush", n_push - p0, 0);
    send_byte(8'h55, 1'b1, 16);
    wait_cyc(32);
    #1;
    chk("t3_push", n_push - p0, 1);
    chk("t3_data", last_data, 8'h55);
    chk("t3_fe_once", n_fe - f0, 1);

    // 4: overrun
    snap();
    rx_fifo_full = 1'b1;
    send_byte(8'h7E, 1'b1, 16);
    wait_cyc(32);
    #1;
    rx_fifo_full = 1'b0;
    chk("t4_ov", n_ov - o0, 1);
    chk("t4_nopush", n_push - p0, 0);
    chk("t4_data_held", rx_data, 8'h55);

    // 5: divider 5, back-to-back frames, 10 bits x 96 clk apart
    freq_divider = 8'd5;
    wait_cyc(20);
    snap();
    send_byte(8'h00, 1'b1, 96);
    send_byte(8'hFF, 1'b1, 96);
    wait_cyc(2 * 96);
    #1;
    chk("t5_push", n_push - p0, 2);
    chk("t5_first", prev_data, 8'h00);
    chk("t5_second", last_data, 8'hFF);
    chk("t5_spacing", last_push_cyc - prev_push_cyc, 960);

    // 6: reset during data bit 4 of 0x12, then 0x81
    freq_divider = 8'd0;
    wait_cyc(20);
    snap();
    rx_bit = 1'b0;                     // start
    wait_cyc(16);
    rx_bit = 1'b0; wait_cyc(16);       // bit0
    rx_bit = 1'b1; wait_cyc(16);       // bit1
    rx_bit = 1'b0; wait_cyc(16);       // bit2
    rx_bit = 1'b0; wait_cyc(16);       // bit3
    rx_bit = 1'b1; wait_cyc(8);        // half of bit4
    reset = 1'b1;
    wait_cyc(1);
    reset = 1'b0;
    wait_cyc(1);
    #1;
    chk("t6_rst_data", rx_data, 8'h00);
    chk("t6_rst_busy", rx_busy, 1'b0);
    wait_cyc(16 * 16);
    #1;
    chk("t6_no_strobes", (n_push - p0) + (n_fe - f0) + (n_ov - o0), 0);
    send_byte(8'h81, 1'b1, 16);
    wait_cyc(32);
    #1;
    chk("t6_push", n_push - p0, 1);
    chk("t6_data", rx_data, 8'h81);
    chk("t6_fe_ov", (n_fe - f0) + (n_ov - o0), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
